// File: rtl/fc_layer_engine.sv
// -----------------------------------------------------------------------------
// fc_layer_engine
//
// Fully-connected layer engine. A run covers GROUPS input vectors. For each
// vector g it produces OUT_NUM neurons:
//   out[g][o] = requant( sum_i d[g][i] * w[o][i] + bias[o] )
// The input, weight and bias memories are external BRAMs with a one-cycle
// read latency. Results leave through a valid/ready handshake.
//
// Each neuron walks ISSUE (IN_NUM reads) -> DRAIN -> POST -> WRITE.
// With out_ready held high a neuron costs IN_NUM+3 cycles, and a run ends
// with a single DONE cycle.
//
// Build option:
//   FC_RELU_EN  when defined, negative results clamp to 0 (ReLU) and positive
//               results saturate to 2^(OUT_W-1)-1. When undefined, results
//               use plain signed saturation to the OUT_W range.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      one-cycle pulse that begins a run; ignored while busy
//   busy       high from the cycle after an accepted start until done
//   done       one-cycle pulse after the last output transfer
//   d_rd_en    input RAM read enable
//   d_addr     input RAM address   = g*IN_NUM + i
//   d_data     input RAM read data, valid the cycle after d_rd_en
//   w_rd_en    weight RAM read enable, asserted together with d_rd_en
//   w_addr     weight RAM address  = o*IN_NUM + i
//   w_data     weight RAM read data, valid the cycle after w_rd_en
//   b_addr     bias RAM address    = o, held for the whole neuron
//   b_data     bias RAM read data
//   out_valid  result valid
//   out_ready  sink ready; a transfer happens on out_valid && out_ready
//   out_addr   result address      = g*OUT_NUM + o
//   out_data   requantised result
// -----------------------------------------------------------------------------
module fc_layer_engine #(
    parameter int IN_NUM  = 480,
    parameter int OUT_NUM = 64,
    parameter int GROUPS  = 42,
    parameter int DATA_W  = 8,
    parameter int W_W     = 8,
    parameter int B_W     = 16,
    parameter int OUT_W   = 8,
    parameter int SHIFT   = 10,
    parameter int ACC_W   = DATA_W + W_W + $clog2(IN_NUM) + 1,
    localparam int DA_W   = (GROUPS * IN_NUM > 1) ? $clog2(GROUPS * IN_NUM) : 1,
    localparam int WA_W   = (OUT_NUM * IN_NUM > 1) ? $clog2(OUT_NUM * IN_NUM) : 1,
    localparam int BA_W   = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1,
    localparam int OA_W   = (GROUPS * OUT_NUM > 1) ? $clog2(GROUPS * OUT_NUM) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              d_rd_en,
    output logic [DA_W-1:0]   d_addr,
    input  logic [DATA_W-1:0] d_data,
    output logic              w_rd_en,
    output logic [WA_W-1:0]   w_addr,
    input  logic [W_W-1:0]    w_data,
    output logic [BA_W-1:0]   b_addr,
    input  logic [B_W-1:0]    b_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OA_W-1:0]   out_addr,
    output logic [OUT_W-1:0]  out_data
);

    localparam int IW  = $clog2(IN_NUM);
    localparam int GW  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int PW  = DATA_W + W_W;
    // Two guard bits above the wider of accumulator and bias: one for the
    // bias add, one for the rounding offset.
    localparam int S_W = ((ACC_W > B_W) ? ACC_W : B_W) + 2;

    localparam logic signed [S_W-1:0] RND =
        (SHIFT > 0) ? (S_W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [S_W-1:0] OMAX =
        {{(S_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [S_W-1:0] OMIN = ~OMAX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_POST,
        S_WRITE,
        S_DONE
    } state_t;

    // Round half up, then arithmetic shift right.
    function automatic logic signed [S_W-1:0] round_shift(input logic signed [S_W-1:0] s);
        return (s + RND) >>> SHIFT;
    endfunction

    // Clamp the shifted sum into the output range.
    function automatic logic [OUT_W-1:0] saturate(input logic signed [S_W-1:0] r);
`ifdef FC_RELU_EN
        if (r[S_W-1]) begin
            return '0;
        end else if (r > OMAX) begin
            return OMAX[OUT_W-1:0];
        end
        return r[OUT_W-1:0];
`else
        if (r > OMAX) begin
            return OMAX[OUT_W-1:0];
        end else if (r < OMIN) begin
            return OMIN[OUT_W-1:0];
        end
        return r[OUT_W-1:0];
`endif
    endfunction

    // Control state
    state_t           state_q, state_d;
    logic [IW-1:0]    i_q, i_d;
    logic [BA_W-1:0]  o_q, o_d;
    logic [GW-1:0]    g_q, g_d;
    logic             vld_p1_q, vld_p1_d;
    logic             first_p1_q, first_p1_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;

    // Datapath state (no reset: first_p1 reloads the accumulator)
    logic signed [ACC_W-1:0] acc_q, acc_d;

    logic signed [DATA_W-1:0] d_s;
    logic signed [W_W-1:0]    w_s;
    logic signed [B_W-1:0]    b_s;
    logic signed [PW-1:0]     prod_p1;
    logic signed [ACC_W-1:0]  prod_ext_p1;
    logic signed [S_W-1:0]    sum_post;
    logic signed [S_W-1:0]    shr_post;
    logic                     last_i;
    logic                     last_o;
    logic                     last_g;

    assign d_s = d_data;
    assign w_s = w_data;
    assign b_s = b_data;

    // Stage p1: RAM data is present the cycle after the read was issued. The
    // product is formed here and folded into the accumulator at the edge.
    assign prod_p1     = PW'(d_s) * PW'(w_s);
    assign prod_ext_p1 = ACC_W'(prod_p1);

    // POST stage: bias add and requantisation on the completed accumulator.
    assign sum_post = S_W'(acc_q) + S_W'(b_s);
    assign shr_post = round_shift(sum_post);

    assign last_i = (i_q == IW'(IN_NUM - 1));
    assign last_o = (o_q == BA_W'(OUT_NUM - 1));
    assign last_g = (g_q == GW'(GROUPS - 1));

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        o_d        = o_q;
        g_d        = g_q;
        vld_p1_d   = 1'b0;
        first_p1_d = 1'b0;
        out_data_d = out_data_q;
        acc_d      = acc_q;

        if (vld_p1_q) begin
            acc_d = first_p1_q ? prod_ext_p1 : acc_q + prod_ext_p1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    i_d     = '0;
                    o_d     = '0;
                    g_d     = '0;
                end
            end
            S_ISSUE: begin
                vld_p1_d   = 1'b1;
                first_p1_d = (i_q == '0);
                if (last_i) begin
                    i_d     = '0;
                    state_d = S_DRAIN;
                end else begin
                    i_d = i_q + IW'(1);
                end
            end
            S_DRAIN: begin
                state_d = S_POST;
            end
            S_POST: begin
                out_data_d = saturate(shr_post);
                state_d    = S_WRITE;
            end
            S_WRITE: begin
                // Holding here while out_ready is low keeps address/data
                // stable and stops any further reads.
                if (out_ready) begin
                    if (last_o) begin
                        o_d = '0;
                        if (last_g) begin
                            g_d     = '0;
                            state_d = S_DONE;
                        end else begin
                            g_d     = g_q + GW'(1);
                            state_d = S_ISSUE;
                        end
                    end else begin
                        o_d     = o_q + BA_W'(1);
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            i_q        <= '0;
            o_q        <= '0;
            g_q        <= '0;
            vld_p1_q   <= 1'b0;
            first_p1_q <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            o_q        <= o_d;
            g_q        <= g_d;
            vld_p1_q   <= vld_p1_d;
            first_p1_q <= first_p1_d;
            out_data_q <= out_data_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_q <= acc_d;
    end

    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign d_rd_en   = (state_q == S_ISSUE);
    assign w_rd_en   = (state_q == S_ISSUE);
    assign out_valid = (state_q == S_WRITE);
    assign out_data  = out_data_q;
    assign b_addr    = o_q;
    assign d_addr    = DA_W'(32'(g_q) * 32'(IN_NUM) + 32'(i_q));
    assign w_addr    = WA_W'(32'(o_q) * 32'(IN_NUM) + 32'(i_q));
    assign out_addr  = OA_W'(32'(g_q) * 32'(OUT_NUM) + 32'(o_q));

endmodule

// File: tb/tb_fc_layer_engine.sv
// -----------------------------------------------------------------------------
// Bench for fc_layer_engine. Two instances share stimulus and memory
// contents: one with SHIFT=0 and one with SHIFT=2. The expected outputs come
// from plain integer dot products over the bench's memory arrays.
// -----------------------------------------------------------------------------
module tb_fc_layer_engine;

    localparam int IN_NUM  = 4;
    localparam int OUT_NUM = 2;
    localparam int GROUPS  = 2;
    localparam int NOUT    = GROUPS * OUT_NUM;
    localparam int RUN_CYC = NOUT * (IN_NUM + 3) + 1;
`ifdef FC_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, out_ready;

    logic       busy0, done0, d_rd_en0, w_rd_en0, out_valid0;
    logic [2:0] d_addr0, w_addr0;
    logic [0:0] b_addr0;
    logic [1:0] out_addr0;
    logic [7:0] d_data0, w_data0, out_data0;
    logic [15:0] b_data0;

    logic       busy2, done2, d_rd_en2, w_rd_en2, out_valid2;
    logic [2:0] d_addr2, w_addr2;
    logic [0:0] b_addr2;
    logic [1:0] out_addr2;
    logic [7:0] d_data2, w_data2, out_data2;
    logic [15:0] b_data2;

    fc_layer_engine #(.IN_NUM(IN_NUM), .OUT_NUM(OUT_NUM), .GROUPS(GROUPS), .DATA_W(8),
                      .W_W(8), .B_W(16), .OUT_W(8), .SHIFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy0), .done(done0),
        .d_rd_en(d_rd_en0), .d_addr(d_addr0), .d_data(d_data0),
        .w_rd_en(w_rd_en0), .w_addr(w_addr0), .w_data(w_data0),
        .b_addr(b_addr0), .b_data(b_data0),
        .out_valid(out_valid0), .out_ready(out_ready), .out_addr(out_addr0), .out_data(out_data0)
    );

    fc_layer_engine #(.IN_NUM(IN_NUM), .OUT_NUM(OUT_NUM), .GROUPS(GROUPS), .DATA_W(8),
                      .W_W(8), .B_W(16), .OUT_W(8), .SHIFT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy2), .done(done2),
        .d_rd_en(d_rd_en2), .d_addr(d_addr2), .d_data(d_data2),
        .w_rd_en(w_rd_en2), .w_addr(w_addr2), .w_data(w_data2),
        .b_addr(b_addr2), .b_data(b_data2),
        .out_valid(out_valid2), .out_ready(out_ready), .out_addr(out_addr2), .out_data(out_data2)
    );

    // Memory contents (bench owned) and one-cycle-latency read ports.
    int dmem [GROUPS*IN_NUM];
    int wmem [OUT_NUM*IN_NUM];
    int bmem [OUT_NUM];

    always @(posedge clk) begin
        if (d_rd_en0) d_data0 <= 8'(dmem[d_addr0]);
        if (w_rd_en0) w_data0 <= 8'(wmem[w_addr0]);
        b_data0 <= 16'(bmem[b_addr0]);
        if (d_rd_en2) d_data2 <= 8'(dmem[d_addr2]);
        if (w_rd_en2) w_data2 <= 8'(wmem[w_addr2]);
        b_data2 <= 16'(bmem[b_addr2]);
    end

    int checks = 0;
    int bad    = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int exp0 [NOUT];
    int exp2 [NOUT];
    int got0 [NOUT];
    int got2 [NOUT];

    function automatic int requant(input int s, input int sh);
        int r;
        int lo;
        r  = (sh > 0) ? ((s + (1 << (sh - 1))) >>> sh) : s;
        lo = RELU ? 0 : -128;
        if (r > 127) r = 127;
        if (r < lo) r = lo;
        return r;
    endfunction

    task automatic build_model();
        for (int g = 0; g < GROUPS; g++) begin
            for (int o = 0; o < OUT_NUM; o++) begin
                int s;
                s = bmem[o];
                for (int i = 0; i < IN_NUM; i++) s += dmem[g*IN_NUM+i] * wmem[o*IN_NUM+i];
                exp0[g*OUT_NUM+o] = requant(s, 0);
                exp2[g*OUT_NUM+o] = requant(s, 2);
                got0[g*OUT_NUM+o] = 999;
                got2[g*OUT_NUM+o] = 999;
            end
        end
    endtask

    // ---------------- per-cycle output compare ----------------
    int   seq = 0;
    bit   hold_pending = 1'b0;
    int   hold_addr, hold_data;

    task automatic compare_outputs();
        if (!rst_n) begin
            hold_pending = 1'b0;
            return;
        end
        if (start && !busy0 && !done0) seq = 0;
        if (out_valid0 !== out_valid2) chk("valid_match", out_valid2, out_valid0);
        if (out_valid0 || d_rd_en0) chk("read_in_write", out_valid0 & d_rd_en0, 0);
        if (d_rd_en0 || w_rd_en0) chk("rd_en_pair", w_rd_en0, d_rd_en0);
        if (hold_pending) begin
            chk("hold_valid", out_valid0, 1);
            chk("hold_addr", out_addr0, hold_addr);
            chk("hold_data", $signed(out_data0), hold_data);
        end
        hold_pending = out_valid0 && !out_ready;
        hold_addr    = out_addr0;
        hold_data    = $signed(out_data0);
        if (out_valid0 && out_ready) begin
            if (seq >= NOUT) begin
                chk("extra_transfer", seq, NOUT - 1);
            end else begin
                chk("out_addr", out_addr0, seq);
                chk("out_addr_s2", out_addr2, seq);
                chk("out_data_s0", $signed(out_data0), exp0[seq]);
                chk("out_data_s2", $signed(out_data2), exp2[seq]);
                got0[seq] = $signed(out_data0);
                got2[seq] = $signed(out_data2);
                seq++;
            end
        end
    endtask

    // Compare at the falling edge, then advance to just after the rising edge.
    task automatic step();
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        #1;
    endtask

    // Start a run and follow it to done; optionally stall the first WRITE.
    task automatic run(input int stall_cycles, input bit coincide_start, output int n);
        int  stall_left;
        bit  stalled;
        stall_left = 0;
        stalled    = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        chk("busy_after_start", busy0, 1);
        while (done0 !== 1'b1 && n < 200) begin
            if (out_valid0 && !stalled && stall_cycles > 0) begin
                out_ready  = 1'b0;
                stalled    = 1'b1;
                stall_left = stall_cycles;
            end
            step();
            n++;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) out_ready = 1'b1;
            end
        end
        chk("done_seen", done0, 1);
        chk("busy_at_done", busy0, 0);
        chk("done_s2", done2, 1);
        chk("transfers", seq, NOUT);
        if (coincide_start) start = 1'b1;
        step();
        start = 1'b0;
        chk("done_pulse", done0, 0);
        chk("idle_after_done", busy0, 0);
    endtask

    task automatic load(input int d [GROUPS*IN_NUM], input int w [OUT_NUM*IN_NUM],
                        input int b [OUT_NUM]);
        dmem = d;
        wmem = w;
        bmem = b;
        build_model();
    endtask

    initial begin
        int n;
        bit done_any;
        rst_n = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        chk("reset_outputs", {busy0, done0, d_rd_en0, w_rd_en0, out_valid0, d_addr0,
                              w_addr0, b_addr0, out_addr0, out_data0}, 0);
        rst_n = 1'b1;
        step();

        // Run 1: basic dot products and saturation; start coincident with done.
        load('{1, 2, 3, 4, 127, 127, 127, 127}, '{1, 1, 1, 1, -1, -1, -1, -1}, '{5, 0});
        run(0, 1'b1, n);
        chk("run1_cycles", n, RUN_CYC);
        chk("lit_sum15", got0[0], 15);
        chk("lit_neg10", got0[1], RELU ? 0 : -10);
        chk("lit_sat_pos", got0[2], 127);
        chk("lit_sat_neg", got0[3], RELU ? 0 : -128);
        chk("lit_s2_15", got2[0], 4);
        chk("lit_s2_neg10", got2[1], RELU ? 0 : -2);
        chk("lit_s2_neg506", got2[3], RELU ? 0 : -127);

        // Run 2: rounding of 6, 5, -6, -7 at SHIFT=2.
        load('{1, 1, 1, 1, -2, -2, -2, -2}, '{1, 1, 1, 1, 1, 1, 1, 1}, '{2, 1});
        run(0, 1'b0, n);
        chk("run2_cycles", n, RUN_CYC);
        chk("lit_rnd6", got2[0], 2);
        chk("lit_rnd5", got2[1], 1);
        chk("lit_rnd_m6", got2[2], RELU ? 0 : -1);
        chk("lit_rnd_m7", got2[3], RELU ? 0 : -2);
        chk("lit_s0_6", got0[0], 6);

        // Run 3: full-scale products with a 5-cycle stall on the first WRITE.
        load('{127, 127, 127, 127, -128, -128, -128, -128},
             '{127, 127, 127, 127, 127, 127, 127, 127}, '{0, 0});
        run(5, 1'b0, n);
        chk("run3_cycles_stall", n, RUN_CYC + 5);
        chk("lit_127sq", got0[0], 127);
        chk("lit_m128x127", got0[2], RELU ? 0 : -128);

        // Run 4: reset during ISSUE aborts the run, then a fresh run completes.
        load('{3, -1, 2, 0, 5, 5, -5, 1}, '{2, -3, 1, 4, -1, 2, 7, -2}, '{-4, 9});
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_busy", busy0, 0);
        chk("abort_valid", out_valid0, 0);
        chk("abort_rd_en", d_rd_en0, 0);
        chk("abort_d_addr", d_addr0, 0);
        done_any = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (done0) done_any = 1'b1;
        end
        chk("abort_no_done", done_any, 0);
        run(0, 1'b0, n);
        chk("run4_cycles", n, RUN_CYC);

        $display("test done: total=%0d bad=%0d", checks, bad);
        $finish;
    end

endmodule
